// File: rtl/service_window_bank.sv
// service_window_bank: bank of NCH independent, TICK-timed service windows
//   CLK       rising-edge clock
//   RSTN      synchronous active-low reset
//   TICK      shared count enable
//   START     per-channel open request
//   ABORT     per-channel close-without-completion request
//   SWLEN     per-channel window length, channel i at [i*W +: W]
//   SWSTAT    per-channel status, 1 = idle, 0 = open (registered)
//   SWDONE    per-channel one-cycle expiry pulse (registered)
//   ANY_OPEN  high while any channel is open
// Optional: define SWB_RETRIGGER_EN to let START restart an open window.
module service_window_bank #(
  parameter int NCH = 4,
  parameter int W   = 16
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           TICK,
  input  logic [NCH-1:0] START,
  input  logic [NCH-1:0] ABORT,
  input  logic [NCH*W-1:0] SWLEN,
  output logic [NCH-1:0] SWSTAT,
  output logic [NCH-1:0] SWDONE,
  output logic           ANY_OPEN
);
`ifdef SWB_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} st_e;
  st_e            st_q  [NCH];
  st_e            st_d  [NCH];
  logic [W-1:0]   cnt_q [NCH];
  logic [W-1:0]   cnt_d [NCH];
  logic [W-1:0]   len_q [NCH];
  logic [W-1:0]   len_d [NCH];
  logic [NCH-1:0] done_q, done_d;
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++) begin
      st_q[i]  <= RSTN ? st_d[i]  : IDLE;
      cnt_q[i] <= RSTN ? cnt_d[i] : '0;
      len_q[i] <= RSTN ? len_d[i] : '0;
    end
    done_q <= RSTN ? done_d : '0;
  end
  // ABORT outranks START and expiry; expiry fires at length-1 so the counter never wraps
  always_comb begin
    done_d = '0;
    for (int i = 0; i < NCH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      len_d[i] = len_q[i];
      if (START[i] && !ABORT[i] && (st_q[i] == IDLE || RETRIG)) begin
        len_d[i]  = SWLEN[i*W +: W];
        cnt_d[i]  = '0;
        st_d[i]   = (SWLEN[i*W +: W] != '0) ? OPEN : IDLE;
        done_d[i] = (SWLEN[i*W +: W] == '0);
      end else if (st_q[i] == OPEN && ABORT[i]) begin
        st_d[i]  = IDLE;
        cnt_d[i] = '0;
      end else if (st_q[i] == OPEN && TICK) begin
        done_d[i] = (cnt_q[i] == len_q[i] - W'(1));
        st_d[i]   = done_d[i] ? IDLE : OPEN;
        cnt_d[i]  = done_d[i] ? '0 : cnt_q[i] + W'(1);
      end
    end
  end
  always_comb begin
    for (int i = 0; i < NCH; i++) SWSTAT[i] = (st_q[i] == IDLE);
    SWDONE = done_q;
  end
  assign ANY_OPEN = ~&SWSTAT;
endmodule

// File: tb/tb_service_window_bank.sv
// tb_service_window_bank: randomized scoreboard bench for service_window_bank
module tb_service_window_bank;
  localparam int NCH = 4;
  localparam int W   = 16;
  logic             CLK = 1'b0;
  logic             RSTN, TICK;
  logic [NCH-1:0]   START, ABORT;
  logic [NCH*W-1:0] SWLEN;
  logic [NCH-1:0]   SWSTAT, SWDONE;
  logic             ANY_OPEN;
  service_window_bank #(.NCH(NCH), .W(W)) dut (
    .CLK(CLK), .RSTN(RSTN), .TICK(TICK), .START(START), .ABORT(ABORT),
    .SWLEN(SWLEN), .SWSTAT(SWSTAT), .SWDONE(SWDONE), .ANY_OPEN(ANY_OPEN)
  );
  always #5 CLK = ~CLK;
  typedef struct packed {
    logic [NCH-1:0] stat;
    logic [NCH-1:0] done;
    logic           any;
  } exp_t;
  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;
  int   rem   [NCH];
  bit   mopen [NCH];
  bit   mdone [NCH];
  task automatic cyc(input logic rstn, input logic tick, input logic [NCH-1:0] st,
                     input logic [NCH-1:0] ab, input logic [NCH*W-1:0] ln);
    exp_t e;
    int   l;
    RSTN = rstn; TICK = tick; START = st; ABORT = ab; SWLEN = ln;
    for (int i = 0; i < NCH; i++) begin
      l = int'(ln[i*W +: W]);
      mdone[i] = 0;
      if (!rstn) begin
        mopen[i] = 0; rem[i] = 0;
      end else if (st[i] && !ab[i] && !mopen[i]) begin
        mopen[i] = (l > 0); rem[i] = l; mdone[i] = (l == 0);
      end else if (mopen[i] && ab[i]) begin
        mopen[i] = 0;
`ifdef SWB_RETRIGGER_EN
      end else if (mopen[i] && st[i]) begin
        mopen[i] = (l > 0); rem[i] = l; mdone[i] = (l == 0);
`endif
      end else if (mopen[i] && tick) begin
        rem[i]--;
        if (rem[i] == 0) begin
          mopen[i] = 0; mdone[i] = 1;
        end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      e.stat[i] = !mopen[i];
      e.done[i] = mdone[i];
    end
    e.any = (e.stat != '1);
    q.push_back(e);
    @(negedge CLK);
  endtask
  task automatic idle(input int n, input logic tick);
    for (int k = 0; k < n; k++) cyc(1, tick, '0, '0, '0);
  endtask
  function automatic logic [NCH*W-1:0] lens(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction
  always @(posedge CLK) begin
    exp_t e;
    cycle++;
    #2;
    if (q.size() != 0) begin
      e = q.pop_front();
      vectors++;
      if ({SWSTAT, SWDONE, ANY_OPEN} !== e) begin
        miscompares++;
        $display("FAIL cycle %0d: swstat/swdone/any_open got %b/%b/%b expected %b/%b/%b",
                 cycle, SWSTAT, SWDONE, ANY_OPEN, e.stat, e.done, e.any);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d miscompares so far", miscompares);
    $finish;
  end
  initial begin
    logic [NCH*W-1:0] ln;
    for (int i = 0; i < NCH; i++) begin
      rem[i] = 0; mopen[i] = 0; mdone[i] = 0;
    end
    for (int k = 0; k < 3; k++) cyc(0, 1, '1, '0, lens(3, 3, 3, 3));
    if (SWSTAT !== '1 || SWDONE !== '0 || ANY_OPEN !== 1'b0) begin
      miscompares++;
      $display("FAIL reset state: swstat/swdone/any_open got %b/%b/%b", SWSTAT, SWDONE, ANY_OPEN);
    end
    cyc(1, 1, 4'b0001, '0, lens(5, 0, 0, 0));
    idle(8, 1);
    cyc(1, 1, 4'b0001, '0, lens(4, 0, 0, 0));
    for (int k = 0; k < 12; k++) cyc(1, k[0], '0, '0, lens(9, 0, 0, 0));
    cyc(1, 1, 4'b0001, '0, lens(10, 0, 0, 0));
    idle(2, 1);
    cyc(1, 1, '0, 4'b0001, '0);
    idle(2, 1);
    cyc(1, 1, 4'b0010, 4'b0010, lens(0, 7, 0, 0));
    idle(2, 1);
    cyc(1, 1, 4'b0100, '0, lens(0, 0, 0, 0));
    idle(2, 1);
    cyc(1, 1, 4'b1000, '0, lens(0, 0, 0, 65535));
    idle(65537, 1);
    cyc(1, 1, 4'b0001, '0, lens(6, 0, 0, 0));
    idle(3, 1);
    cyc(1, 1, 4'b0001, '0, lens(6, 0, 0, 0));
    idle(10, 1);
    cyc(1, 1, 4'b1111, '0, lens(3, 5, 7, 9));
    idle(3, 1);
    cyc(0, 1, 4'b1111, '0, lens(3, 5, 7, 9));
    cyc(1, 1, 4'b0110, '0, lens(1, 2, 0, 4));
    idle(4, 1);
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < NCH; i++)
        ln[i*W +: W] = ($urandom_range(0, 15) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
          NCH'($urandom) & NCH'($urandom), NCH'($urandom) & NCH'($urandom) & NCH'($urandom), ln);
    end
    for (int k = 0; k < 3; k++) cyc(0, 1, '0, '0, '0);
    @(posedge CLK);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/service_window_bank.md
SERVICE_WINDOW_BANK -- requirements
Module: service_window_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent service-window channels, 1..16.
REQ-002 Parameter W, default 16: width of each window-length field and counter.
REQ-003 CLK  input  1: single clock; all state changes on its rising edge.
REQ-004 RSTN  input  1: reset, synchronous and active-low.
REQ-005 TICK  input  1: count enable shared by all channels; tie high to count every cycle.
REQ-006 START  input  NCH: per-channel request to open a window, sampled each cycle.
REQ-007 ABORT  input  NCH: per-channel request to close an open window without completion.
REQ-008 SWLEN  input  NCH*W: per-channel window length in TICKs; channel i uses bits [i*W+W-1 : i*W].
REQ-009 SWSTAT  output  NCH: per-channel status; 1 = idle/closed, 0 = window open; registered.
REQ-010 SWDONE  output  NCH: per-channel one-cycle pulse on normal window expiry; registered.
REQ-011 ANY_OPEN  output  1: high when any SWSTAT bit is 0; combinational from SWSTAT.

Function
REQ-012 Each channel has two states, IDLE (SWSTAT=1) and OPEN (SWSTAT=0), a W-bit counter and a W-bit latched length.
REQ-013 IDLE, START=1, ABORT=0: latch SWLEN field, counter=0; if latched value nonzero go OPEN next cycle, else stay IDLE and pulse SWDONE next cycle.
REQ-014 OPEN, TICK=1, counter==latched length-1: go IDLE, counter=0, SWDONE=1 next cycle.
REQ-015 OPEN, TICK=1, otherwise: counter+1; OPEN, TICK=0: counter holds.
REQ-016 With TICK held high and length L>0, SWSTAT is 0 for exactly L cycles, starting the cycle after START; SWDONE is high on the first cycle SWSTAT is back at 1.
REQ-017 OPEN, ABORT=1: go IDLE next cycle, counter=0, no SWDONE; ABORT beats expiry and START in the same cycle.
REQ-018 IDLE, START=1 and ABORT=1 together: ABORT wins, channel stays IDLE, no SWDONE.
REQ-019 SWLEN changes while OPEN do not affect the running window; only the latched value is used.
REQ-020 SWDONE is high for exactly one cycle per expiry and is 0 in all other cycles.
REQ-021 Channels are fully independent; simultaneous events on different channels are each handled per REQ-013..REQ-018.
REQ-022 L = 2^W-1 is legal; the counter never wraps, because expiry fires at latched length-1.

Reset
REQ-023 RSTN=0 at a rising CLK edge: all channels IDLE, SWSTAT all 1, SWDONE all 0, counters and latched lengths 0.
REQ-024 Reset mid-window: the window is discarded with no SWDONE; START is ignored while RSTN=0.
REQ-025 In the first cycle after RSTN returns high, a START is accepted normally.

Configuration
REQ-026 Macro SWB_RETRIGGER_EN.
REQ-027 Defined: START=1 and ABORT=0 in OPEN relatches SWLEN and clears the counter; the channel stays OPEN, or goes IDLE with a SWDONE pulse if the new length is 0. Retrigger beats expiry in the same cycle; no SWDONE is issued for the superseded window.
REQ-028 Not defined: START while OPEN is ignored, and the window runs to expiry or ABORT.

Verification
REQ-029 Reset, then channel 0 with SWLEN=5, TICK=1 and a 1-cycle START -> SWSTAT[0]=0 for 5 cycles, then SWDONE[0] pulses once as SWSTAT[0] returns to 1; other channels stay 1.
REQ-030 SWLEN=4, TICK high on alternate cycles -> SWSTAT low for 8 cycles, then one SWDONE pulse.
REQ-031 SWLEN=10, ABORT on the 3rd open cycle -> SWSTAT=1 on the next cycle with no SWDONE; START and ABORT together in IDLE -> no state change.
REQ-032 SWLEN=0 with START -> SWSTAT stays 1 and SWDONE pulses one cycle later; SWLEN=16'hFFFF -> window of 65535 cycles.
REQ-033 SWLEN=6 with START, START repeated at open cycle 4 -> SWB_RETRIGGER_EN defined: window closes 6 cycles after the second START, with one SWDONE; not defined: closes at the original 6 cycles.
REQ-034 Open all 4 channels with lengths 3,5,7,9 and assert RSTN=0 at cycle 4 -> all SWSTAT=1, no SWDONE, ANY_OPEN=0.
